// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the rvseed instruction fetch stage.
// Also provides the core-wide width macros when no other header has set them.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INST_MEM_ADDR_WIDTH
`define INST_MEM_ADDR_WIDTH 10
`endif

package fetch_unit_pkg;

    localparam logic [`CPU_WIDTH-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [`CPU_WIDTH-1:0] PC_INCR          = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [`CPU_WIDTH-1:0] pc;
        logic [`CPU_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [`CPU_WIDTH-1:0] align_pc(input logic [`CPU_WIDTH-1:0] pc);
        return {pc[`CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: fetch is the master presenting {inst, pc}, decode
// is the slave driving out_ready.
interface fetch_unit_if;

    logic                  out_valid;
    logic                  out_ready;
    logic [`CPU_WIDTH-1:0] out_inst;
    logic [`CPU_WIDTH-1:0] out_pc;

    modport master (
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Two-entry FIFO of {pc, inst} between fetch and decode. The head register keeps
// its last contents when the queue drains or is flushed.
module fetch_unit_queue
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t tail;

    // Pop only shifts tail into head when a second entry exists, so a drained
    // queue still shows the last instruction on its head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_entry;
                    end else begin
                        tail <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= push_entry;
                    end else begin
                        head <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rvseed fetch stage: owns the PC, samples imem into a 2-entry queue for decode.
// Optional FETCH_PERF_CNT_EN adds push and full-stall performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [`CPU_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [`CPU_WIDTH-1:0] curr_pc,
    input  logic [`CPU_WIDTH-1:0] inst,
    input  logic                  redirect_en,
    input  logic [`CPU_WIDTH-1:0] redirect_pc,
    fetch_unit_if.master          dec
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    generate
        if (QUEUE_DEPTH != 2 || RESET_PC[1:0] != 2'b00) begin : g_bad_config
            $error("fetch_unit: QUEUE_DEPTH must be 2 and RESET_PC word aligned");
        end
    endgenerate

    fetch_state_e state;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t new_entry;
    logic         push;
    logic         pop;
    logic         will_fill;

    assign pop       = dec.out_valid && dec.out_ready;
    assign push      = (state != BOOT) && !redirect_en && ((q_count != 2'd2) || pop);
    assign will_fill = !pop && ((q_count == 2'd2) || (q_count == 2'd1 && push));
    assign new_entry = '{pc: curr_pc, inst: inst};

    // Redirect overrides everything, including a pending BOOT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            curr_pc <= RESET_PC;
        end else if (redirect_en) begin
            state   <= RUN;
            curr_pc <= align_pc(redirect_pc);
        end else begin
            if (push) begin
                curr_pc <= curr_pc + PC_INCR;
            end
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (will_fill) state <= FULL;
                FULL:    if (pop) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    fetch_unit_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_en),
        .push_entry (new_entry),
        .count      (q_count),
        .head       (q_head)
    );

    assign dec.out_valid = (q_count != 2'd0);
    assign dec.out_inst  = q_head.inst;
    assign dec.out_pc    = q_head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (state == FULL && !pop) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed timing checks plus a scoreboard that follows
// the in-order program stream seen by decode, restarting at each redirect target.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] curr_pc;
    logic [31:0] inst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int hs;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_head;

    fetch_unit_if dec ();

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .curr_pc     (curr_pc),
        .inst        (inst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dec         (dec)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    assign inst = memWord(curr_pc);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the next cycle's inputs just after the edge, then wait to mid-cycle.
    task automatic applyStimulus(input logic rdy, input logic ren, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        dec.out_ready = rdy;
        redirect_en   = ren;
        redirect_pc   = rpc;
        @(negedge clk);
    endtask

    // Leaves the bench at mid-cycle 0 after reset release, with given cycle-0 inputs.
    task automatic resetDut(input logic rdy, input logic ren, input logic [31:0] rpc);
        rst_n         = 1'b0;
        dec.out_ready = rdy;
        redirect_en   = ren;
        redirect_pc   = rpc;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference stream: program order from reset PC, restarting at each redirect.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = RST_PC;
        end else begin
            while (exp_q.size() < 4) begin
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (dec.out_valid && dec.out_ready) begin
                exp_head = exp_q.pop_front();
                checkOutput("stream_pc", dec.out_pc, exp_head);
                checkOutput("stream_inst", dec.out_inst, memWord(exp_head));
            end
            if (redirect_en) begin
                exp_q.delete();
                exp_pc = redirect_pc & ~32'h3;
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        dec.out_ready = 1'b0;
        redirect_en   = 1'b0;
        redirect_pc   = 32'h0;

        $display("[TB] reset release and streaming");
        resetDut(1'b1, 1'b0, 32'h0);
        checkOutput("boot_valid", 32'(dec.out_valid), 32'h0);
        checkOutput("boot_curr_pc", curr_pc, RST_PC);
        checkOutput("reset_out_pc", dec.out_pc, 32'h0);
        checkOutput("reset_out_inst", dec.out_inst, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("c1_valid", 32'(dec.out_valid), 32'h0);
        checkOutput("c1_curr_pc", curr_pc, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("c2_valid", 32'(dec.out_valid), 32'h1);
        checkOutput("c2_out_pc", dec.out_pc, 32'h0);
        checkOutput("c2_out_inst", dec.out_inst, 32'h1000_0000);
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) applyStimulus(1'b1, 1'b0, 32'h0);
            if (dec.out_valid) hs++;
        end
        checkOutput("throughput", 32'(hs), 32'd10);
        checkOutput("c11_out_pc", dec.out_pc, 32'h24);

        $display("[TB] backpressure and drain");
        resetDut(1'b0, 1'b0, 32'h0);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stall_curr_pc", curr_pc, 32'h8);
        checkOutput("stall_valid", 32'(dec.out_valid), 32'h1);
        checkOutput("stall_head_pc", dec.out_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("drain0_pc", dec.out_pc, 32'h0);
        checkOutput("drain0_curr_pc", curr_pc, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("drain1_pc", dec.out_pc, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("resume_pc", dec.out_pc, 32'h8);

        $display("[TB] redirect while full");
        resetDut(1'b0, 1'b0, 32'h0);
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0203);
        checkOutput("full_valid", 32'(dec.out_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_curr_pc", curr_pc, 32'h200);
        checkOutput("redir_flush_valid", 32'(dec.out_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_valid", 32'(dec.out_valid), 32'h1);
        checkOutput("redir_out_pc", dec.out_pc, 32'h200);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] redirect with handshake, then async reset");
        applyStimulus(1'b1, 1'b1, 32'h0000_0400);
        checkOutput("redir_hs_valid", 32'(dec.out_valid), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_hs_curr_pc", curr_pc, 32'h400);
        checkOutput("redir_hs_gap", 32'(dec.out_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_hs_out_pc", dec.out_pc, 32'h400);
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(dec.out_valid), 32'h0);
        checkOutput("async_curr_pc", curr_pc, RST_PC);
        checkOutput("async_out_pc", dec.out_pc, 32'h0);
        checkOutput("async_out_inst", dec.out_inst, 32'h0);

        $display("[TB] redirect during boot");
        resetDut(1'b1, 1'b1, 32'h0000_0082);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("boot_redir_curr_pc", curr_pc, 32'h80);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("boot_redir_valid", 32'(dec.out_valid), 32'h1);
        checkOutput("boot_redir_out_pc", dec.out_pc, 32'h80);

        $display("[TB] address wrap");
        resetDut(1'b1, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap0_pc", dec.out_pc, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap1_pc", dec.out_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap2_pc", dec.out_pc, 32'h0);
        checkOutput("wrap2_inst", dec.out_inst, 32'h1000_0000);

        $display("[TB] randomized traffic");
        resetDut(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                          $urandom);
        end

`ifdef FETCH_PERF_CNT_EN
        $display("[TB] performance counters");
        resetDut(1'b0, 1'b0, 32'h0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("perf_fetch", perf_fetch_cnt, 32'd2);
        checkOutput("perf_stall", perf_stall_cnt, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
